// File: rtl/audio_mixer_pwm.sv
// Tone mixer with master fade envelope, driving a single PWM speaker pin.
// Each tone is gated by its gain and the gated gains are summed. The sum is scaled,
// saturated and faded once per PWM period, and becomes the duty for the next period.
module audio_mixer_pwm #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned GAIN_W     = 4,
  parameter int unsigned PWM_W      = 8,
  parameter int unsigned DUTY_SCALE = 4,
  parameter int unsigned FADE_DIV   = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        tone_in,
  input  logic [NUM_CH*GAIN_W-1:0] ch_gain,
  input  logic                     mute,
  output logic                     audio_pwm_out,
  output logic                     sample_tick,
  output logic                     clip,
  output logic [4:0]               fade_level
);

  localparam int unsigned SumW     = GAIN_W + $clog2(NUM_CH) + $clog2(DUTY_SCALE) + 1;
  localparam int unsigned CmpW     = (SumW > PWM_W) ? SumW : PWM_W;
  localparam int unsigned FadeCntW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam int unsigned ProdW    = PWM_W + 5;

  localparam logic [PWM_W-1:0]    CntMax   = '1;
  localparam logic [FadeCntW-1:0] FadeLast = FadeCntW'(FADE_DIV - 1);
  localparam logic [4:0]          FadeFull = 5'd16;

  logic [NUM_CH-1:0]   tone_q;
  logic [PWM_W-1:0]    pwm_cnt;
  logic [PWM_W-1:0]    duty_q;
  logic [FadeCntW-1:0] fade_cnt;
  logic [FadeCntW-1:0] fade_cnt_d;
  logic [4:0]          fade_level_d;

  logic [SumW-1:0]  raw_sum;
  logic [SumW-1:0]  scaled;
  logic [CmpW-1:0]  scaled_w;
  logic             clip_next;
  logic [PWM_W-1:0] sat;
  logic [ProdW-1:0] prod;
  logic [PWM_W-1:0] duty;
  logic             wrap;

  assign wrap = (pwm_cnt == CntMax);

  // Gated gain sum, scaling, saturation and fade scaling of the next duty.
  always_comb begin
    raw_sum = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (tone_q[i]) begin
        raw_sum = raw_sum + SumW'(ch_gain[i*GAIN_W +: GAIN_W]);
      end
    end
    scaled    = raw_sum * SumW'(DUTY_SCALE);
    scaled_w  = CmpW'(scaled);
    clip_next = (scaled_w > CmpW'(CntMax));
    sat       = clip_next ? CntMax : PWM_W'(scaled_w);
    prod      = ProdW'(sat) * ProdW'(fade_level);
    duty      = prod[PWM_W+3:4];
  end

  // Fade envelope: one step every FADE_DIV periods, direction chosen by mute at the step.
  always_comb begin
    fade_cnt_d   = fade_cnt;
    fade_level_d = fade_level;
    if (wrap) begin
      if (fade_cnt == FadeLast) begin
        fade_cnt_d = '0;
        if (mute && (fade_level != 5'd0)) begin
          fade_level_d = fade_level - 5'd1;
        end else if (!mute && (fade_level < FadeFull)) begin
          fade_level_d = fade_level + 5'd1;
        end
      end else begin
        fade_cnt_d = fade_cnt + FadeCntW'(1);
      end
    end
  end

  // Counter, per-period duty/clip load, envelope state and registered PWM output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_q        <= '0;
      pwm_cnt       <= '0;
      duty_q        <= '0;
      audio_pwm_out <= 1'b0;
      sample_tick   <= 1'b0;
      clip          <= 1'b0;
      fade_level    <= 5'd0;
      fade_cnt      <= '0;
    end else begin
      tone_q        <= tone_in;
      pwm_cnt       <= pwm_cnt + PWM_W'(1);
      audio_pwm_out <= (pwm_cnt < duty_q);
      sample_tick   <= wrap;
      fade_level    <= fade_level_d;
      fade_cnt      <= fade_cnt_d;
      // Duty uses the pre-step fade level; a new level shows one period later.
      if (wrap) begin
        duty_q <= duty;
        clip   <= clip_next;
      end
    end
  end

endmodule

// File: tb/tb_audio_mixer_pwm.sv
// Directed bench for audio_mixer_pwm. Two instances share the stimulus: one with the
// default duty scale (4) and one with scale 5 to reach saturation. The fade divider is
// shortened to 2 periods per step so full envelope traversals stay short.
module tb_audio_mixer_pwm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  tone_in;
  logic [15:0] ch_gain;
  logic        mute;

  logic       out_a, tick_a, clip_a;
  logic [4:0] fade_a;
  logic       out_b, tick_b, clip_b;
  logic [4:0] fade_b;

  audio_mixer_pwm #(
    .NUM_CH(4), .GAIN_W(4), .PWM_W(8), .DUTY_SCALE(4), .FADE_DIV(2)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .tone_in(tone_in), .ch_gain(ch_gain), .mute(mute),
    .audio_pwm_out(out_a), .sample_tick(tick_a), .clip(clip_a), .fade_level(fade_a)
  );

  audio_mixer_pwm #(
    .NUM_CH(4), .GAIN_W(4), .PWM_W(8), .DUTY_SCALE(5), .FADE_DIV(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .tone_in(tone_in), .ch_gain(ch_gain), .mute(mute),
    .audio_pwm_out(out_b), .sample_tick(tick_b), .clip(clip_b), .fade_level(fade_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int wrap_n;
  int ha, hb, fa, la, ta, tpos;
  int sum_h, sum_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One full PWM period starting just after a wrap edge; optional mid-period gain
  // change with a short mute glitch at sample act_at.
  task automatic run_period(input int act_at, input logic [15:0] new_gain);
    ha = 0; hb = 0; fa = 0; la = 0; ta = 0; tpos = 0;
    for (int k = 1; k <= 256; k++) begin
      @(posedge clk);
      #1;
      if (out_a === 1'b1) begin
        ha++;
        if (fa == 0) fa = k;
        la = k;
      end
      if (out_b === 1'b1) hb++;
      if (tick_a === 1'b1) begin
        ta++;
        tpos = k;
      end
      if (act_at == k) begin
        ch_gain = new_gain;
        mute    = 1'b1;
      end
      if (act_at > 0 && k == act_at + 3) mute = 1'b0;
    end
    wrap_n++;
  endtask

  initial begin
    rst_n   = 1'b0;
    tone_in = 4'b0000;
    ch_gain = 16'h0000;
    mute    = 1'b0;
    wrap_n  = 0;
    #2;
    check("rst_out", out_a, 0);
    check("rst_tick", tick_a, 0);
    check("rst_clip", clip_a, 0);
    check("rst_fade", fade_a, 0);
    clocks(3);
    @(negedge clk);
    rst_n = 1'b1;

    // Silent fade-in.
    clocks(255);
    check("first_tick_early", tick_a, 0);
    clocks(1);
    check("first_tick", tick_a, 1);
    check("fade_wrap1", fade_a, 0);
    wrap_n = 1;
    sum_h = 0;
    sum_t = 0;
    repeat (30) begin
      run_period(0, 16'h0);
      sum_h += ha + hb;
      sum_t += ta;
      if (tpos != 256) sum_t += 1000;
    end
    check("silent_highs", sum_h, 0);
    check("tick_every_256", sum_t, 30);
    check("fade_15", fade_a, 15);
    run_period(0, 16'h0);
    check("fade_16", fade_a, 16);
    run_period(0, 16'h0);
    run_period(0, 16'h0);
    check("fade_hold_16", fade_a, 16);
    check("fade_hold_16_b", fade_b, 16);

    // Single channel, gain 15.
    ch_gain = 16'h000F;
    tone_in = 4'b0001;
    run_period(0, 16'h0);
    run_period(0, 16'h0);
    check("ch0_highs", ha, 60);
    check("ch0_first", fa, 1);
    check("ch0_last", la, 60);
    check("ch0_highs_b", hb, 75);
    check("ch0_clip", clip_a, 0);
    check("ch0_clip_b", clip_b, 0);

    // All channels full: 240 unclipped, 300 saturates to 255 on the scale-5 instance.
    ch_gain = 16'hFFFF;
    tone_in = 4'b1111;
    run_period(0, 16'h0);
    check("all_clip", clip_a, 0);
    check("all_clip_b", clip_b, 1);
    run_period(0, 16'h0);
    check("all_highs", ha, 240);
    check("all_highs_b", hb, 255);

    // Fade-out under mute, aligned so steps land on every second wrap after mute rises.
    if (wrap_n % 2 != 0) run_period(0, 16'h0);
    mute = 1'b1;
    run_period(0, 16'h0);
    run_period(0, 16'h0);
    check("mute_fade_15", fade_a, 15);
    run_period(0, 16'h0);
    check("pre_step_duty", ha, 240);
    run_period(0, 16'h0);
    check("faded_duty_15", ha, 225);
    check("faded_duty_15_b", hb, 239);
    repeat (28) run_period(0, 16'h0);
    check("mute_fade_0", fade_a, 0);
    run_period(0, 16'h0);
    check("last_faded_duty", ha, 15);
    check("last_faded_duty_b", hb, 15);
    check("clip_through_fade", clip_b, 1);
    run_period(0, 16'h0);
    check("muted_silent", ha, 0);
    check("muted_silent_b", hb, 0);

    // Fade back in with ch0 only; observe duties at level 8 and ignore a mute glitch.
    mute    = 1'b0;
    ch_gain = 16'h000F;
    tone_in = 4'b0001;
    run_period(0, 16'h0);
    run_period(0, 16'h0);
    check("unmute_fade_1", fade_a, 1);
    repeat (15) run_period(0, 16'h0);
    check("fade_8", fade_a, 8);
    run_period(100, 16'h0005);
    check("lvl8_g15", ha, 30);
    check("lvl8_g15_b", hb, 37);
    check("glitch_ignored", fade_a, 9);
    run_period(0, 16'h0);
    check("lvl8_g5", ha, 10);
    check("lvl8_g5_b", hb, 12);
    repeat (13) run_period(0, 16'h0);
    check("refade_16", fade_a, 16);

    // Asynchronous reset mid-period with output high.
    ch_gain = 16'hFFFF;
    tone_in = 4'b1111;
    run_period(0, 16'h0);
    run_period(0, 16'h0);
    clocks(100);
    check("pre_rst_out", out_a, 1);
    check("pre_rst_clip_b", clip_b, 1);
    rst_n = 1'b0;
    #1;
    check("async_out", out_a, 0);
    check("async_out_b", out_b, 0);
    check("async_tick", tick_a, 0);
    check("async_clip_b", clip_b, 0);
    check("async_fade", fade_a, 0);
    check("async_fade_b", fade_b, 0);
    clocks(3);
    @(negedge clk);
    rst_n = 1'b1;
    clocks(255);
    check("re_tick_early", tick_a, 0);
    clocks(1);
    check("re_tick", tick_a, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_mixer_pwm.md
Name: audio_mixer_pwm

Overview:
Downstream stage for the 1-bit square-wave sound generators (jump, squash, score, timer tones). It gates each tone by a per-channel gain and sums the gated channels into a duty level once per PWM period. A master fade envelope scales that level, and the block drives a single PWM pin to the board speaker/audio filter. Runs on the 25.1 MHz pixel clock. The fade envelope removes pops at power-up and on mute.

Parameters:
NUM_CH, 4, number of 1-bit tone inputs (ch0 = jump tone)
GAIN_W, 4, width of each channel gain
PWM_W, 8, PWM counter width; period = 2^PWM_W clocks
DUTY_SCALE, 4, integer multiplier applied to the raw gain sum
FADE_DIV, 64, PWM periods per fade step

Ports:
clk  in  1  system clock, 25.1 MHz
rst_n  in  1  asynchronous active-low reset
tone_in  in  NUM_CH  1-bit square tones from the sound generators
ch_gain  in  NUM_CH*GAIN_W  per-channel gain; ch i at bits [i*GAIN_W +: GAIN_W]
mute  in  1  request fade-out to silence; 0 = fade-in to full
audio_pwm_out  out  1  registered PWM output
sample_tick  out  1  one-cycle pulse when a new duty is loaded
clip  out  1  previous period's level saturated
fade_level  out  5  current envelope value, 0..16

Behaviour:
- Reset (async, rst_n=0) clears all state: pwm_cnt=0, duty_q=0, audio_pwm_out=0, sample_tick=0, clip=0, fade_level=0, fade_cnt=0, tone_q=0. After reset the block starts silent and fades in.
- tone_in is registered once into tone_q, giving 1 clock of input latency.
- pwm_cnt is PWM_W bits, free-running, increments every clock and wraps from 2^PWM_W-1 to 0.
- Raw sum = Σ over channels of (tone_q[i] ? gain[i] : 0). The sum is unsigned, with width GAIN_W+clog2(NUM_CH)+clog2(DUTY_SCALE)+1 so no overflow occurs.
- Scaled = raw sum * DUTY_SCALE.
- Sat = min(scaled, 2^PWM_W-1).
- clip_next = (scaled > 2^PWM_W-1).
- Duty = (sat * fade_level) >> 4, truncated. fade_level=16 gives duty = sat; fade_level=0 gives duty = 0.
- On the cycle pwm_cnt == 2^PWM_W-1:
  - duty_q <= duty.
  - clip <= clip_next.
  - sample_tick <= 1 on the following edge; sample_tick is high during the cycle pwm_cnt == 0.
  - All other cycles sample_tick = 0.
- audio_pwm_out <= (pwm_cnt < duty_q), registered. Output is high for exactly duty_q clocks per period, delayed 1 cycle relative to pwm_cnt.
- duty_q = 0 holds the output constantly 0. Max duty 2^PWM_W-1 gives 255 high and 1 low clocks per period.
- Fade envelope:
  - fade_cnt counts PWM periods, advancing on the wrap cycle.
  - When fade_cnt reaches FADE_DIV-1, it resets to 0 and takes a fade step:
    - If mute=1 and fade_level>0, fade_level decrements by 1.
    - If mute=0 and fade_level<16, fade_level increments by 1.
    - Otherwise fade_level holds.
  - mute is sampled only at the step boundary. Toggling mute mid-interval has no effect until the next step, and a glitch between steps is ignored.
  - A step updates fade_level on the same wrap edge that duty_q loads. The loaded duty uses the pre-step fade_level, so the new level takes effect one period later.
  - Full traversal 0→16 takes 16*FADE_DIV periods = 262144 clocks (~10.4 ms) at defaults.
- Tone inputs and gains may change at any time. Only values present in tone_q/ch_gain on the wrap cycle affect the next period.
- Reset asserted mid-period clears everything immediately. After release the counter restarts at 0 and the first sample_tick occurs 256 clocks later.

Test Plan:
1. Reset release, mute=0, all gains 0 → audio_pwm_out stays 0. sample_tick pulses every 256 clocks. fade_level reaches 16 after exactly 1024 periods and stays there.
2. After fade-in: ch0 gain=15, tone_in=0001 held → duty 60. Output is high for exactly 60 of every 256 clocks, starting 1 clock after pwm_cnt wraps to 0. clip=0.
3. All four channels gain=15, tones=1111 → duty 240, clip=0. Rerun with bench DUTY_SCALE=5 → scaled 300, duty 255, clip=1 from the next sample_tick.
4. Full output, then assert mute → fade_level drops by 1 every 64 periods and reaches 0 after 1024 periods, after which output is constantly 0. Deassert mute → fade_level climbs back to 16.
5. fade_level frozen at 8 (mute toggled at step boundaries), ch0 gain 15 tone 1 → duty (60*8)>>4 = 30. With gain 5 → duty (20*8)>>4 = 10.
6. Pull rst_n low at pwm_cnt=100 with output high → output, sample_tick, clip and fade_level go to 0 asynchronously without waiting for a clock edge. After release, the first sample_tick arrives 256 clocks later.
